// File: rtl/ex_regincr_reg_decr_pipe.sv
// ex_regincr_reg_decr_pipe: elastic val/rdy pipeline subtracting p_decr in every stage
module ex_regincr_reg_decr_pipe #(
  parameter int p_nbits = 8,
  parameter int p_nstages = 2,
  parameter logic [p_nbits-1:0] p_decr = p_nbits'(1)
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               in_val,
  output logic                               in_rdy,
  input  logic [p_nbits-1:0]                 in_msg,
  output logic                               out_val,
  input  logic                               out_rdy,
  output logic [p_nbits-1:0]                 out_msg,
  output logic [$clog2(p_nstages+1)-1:0]     occ
);
  localparam int ow = $clog2(p_nstages + 1);
  logic [p_nstages-1:0] val, adv, ld;
  logic [p_nstages:0]   go;
  logic [p_nbits-1:0]   data [p_nstages];
  logic [p_nbits-1:0]   src  [p_nstages];
  logic                 in_fire, out_fire, acc;
  // go[i] closed form: a stage can take data if downstream drains or any stage at/after it is empty
  always_comb begin
    acc = 1'b1;
    go[p_nstages] = out_rdy;
    for (int i = p_nstages - 1; i >= 0; i--) begin
      acc = acc & val[i];
      go[i] = out_rdy | ~acc;
    end
  end
  assign adv      = val & go[p_nstages:1];
  assign in_rdy   = go[0] & ~reset;
  assign in_fire  = in_val & in_rdy;
  assign out_val  = val[p_nstages-1];
  assign out_msg  = data[p_nstages-1];
  assign out_fire = out_val & out_rdy;
  always_comb begin
    ld[0]  = in_fire;
    src[0] = in_msg;
    for (int i = 1; i < p_nstages; i++) begin
      ld[i]  = adv[i-1];
      src[i] = data[i-1];
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      val <= '0;
      occ <= '0;
      for (int i = 0; i < p_nstages; i++) data[i] <= '0;
    end else begin
      for (int i = 0; i < p_nstages; i++) begin
        if (ld[i]) begin
          val[i]  <= 1'b1;
          data[i] <= src[i] - p_decr;
        end else if (adv[i]) begin
          val[i]  <= 1'b0;
        end
      end
      occ <= occ + ow'(in_fire) - ow'(out_fire);
    end
  end
endmodule
